// File: rtl/tu56_fe_tape_server.sv
// tu56_fe_tape_server
//   Hardware front-end for the tu56 transport. Serves the transport's fe_rq
//   requests from a tape image held in Avalon-MM style memory (one tape line
//   per byte, low nibble), tracks the current line position and steps it
//   forward/reverse after every access.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   fe_rq[0:3]          {fe_rq[0],fe_rq[1]} motion (2=fwd, 3=rev, else none),
//                       fe_rq[2] transport has a line to write, fe_rq[3] wants a line
//   fe_readdata         [4]=WRTM (store all 4 bits), [3:0] line from transport
//   fe_address          transport register select, tied 0
//   fe_read/fe_write    one-cycle strobes towards the transport
//   fe_writedata        {4'b0, line} presented with fe_write
//   mem_*               Avalon-MM master (address = BASE + pos)
//   pos_load, pos_in    host seek, honoured only while idle, clamped to TAPE_LEN-1
//   pos                 current tape line position
//   eot                 sticky: a step was clamped at either end; cleared by pos_load
//   busy                FSM not idle
module tu56_fe_tape_server #(
  parameter int TAPE_LEN = 922512,
  parameter int AW       = 20,
  parameter int BASE     = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [0:3]    fe_rq,
  input  logic [4:0]    fe_readdata,
  output logic          fe_address,
  output logic          fe_read,
  output logic          fe_write,
  output logic [7:0]    fe_writedata,
  output logic [AW-1:0] mem_address,
  output logic          mem_read,
  output logic          mem_write,
  output logic [7:0]    mem_writedata,
  input  logic [7:0]    mem_readdata,
  input  logic          mem_waitrequest,
  input  logic          mem_readdatavalid,
  input  logic          pos_load,
  input  logic [AW-1:0] pos_in,
  output logic [AW-1:0] pos,
  output logic          eot,
  output logic          busy
);

  localparam logic [AW-1:0] LAST   = AW'(TAPE_LEN - 1);
  localparam logic [AW-1:0] BASE_A = AW'(BASE);

  typedef enum logic [3:0] {
    S_IDLE,
    S_TAKE,
    S_RMW_RD,
    S_RMW_WAIT,
    S_MWR,
    S_FETCH,
    S_FWAIT,
    S_GIVE,
    S_STEP
  } state_t;

  state_t     state;
  logic       prev_wr, prev_rd;
  logic       pend_wr, pend_rd;
  logic [1:0] mot_wr, mot_rd, mot;
  logic [2:0] data_keep;   // data bits of a non-WRTM write, waiting for the mark bit
  logic [1:0] motion_now;
  logic       wr_rise, rd_rise;
  logic       unused_bits;

  assign motion_now  = {fe_rq[0], fe_rq[1]};
  assign wr_rise     = fe_rq[2] & ~prev_wr;
  assign rd_rise     = fe_rq[3] & ~prev_rd;
  assign fe_address  = 1'b0;
  assign mem_address = BASE_A + pos;
  assign busy        = (state != S_IDLE);
  assign unused_bits = &{1'b0, mem_readdata[7:4]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      prev_wr       <= 1'b0;
      prev_rd       <= 1'b0;
      pend_wr       <= 1'b0;
      pend_rd       <= 1'b0;
      mot_wr        <= 2'd0;
      mot_rd        <= 2'd0;
      mot           <= 2'd0;
      data_keep     <= 3'd0;
      fe_read       <= 1'b0;
      fe_write      <= 1'b0;
      fe_writedata  <= 8'h00;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_writedata <= 8'h00;
      pos           <= '0;
      eot           <= 1'b0;
    end else begin
      prev_wr <= fe_rq[2];
      prev_rd <= fe_rq[3];

      case (state)
        S_IDLE: begin
          // A seek takes the cycle; any pending request starts on the next one.
          if (pos_load) begin
            pos <= (pos_in > LAST) ? LAST : pos_in;
            eot <= 1'b0;
          end else if (pend_wr) begin
            pend_wr <= 1'b0;
            mot     <= mot_wr;
            fe_read <= 1'b1;
            state   <= S_TAKE;
          end else if (pend_rd) begin
            pend_rd  <= 1'b0;
            mot      <= mot_rd;
            mem_read <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_TAKE: begin
          fe_read <= 1'b0;
          if (fe_readdata[4]) begin
            mem_writedata <= {4'b0, fe_readdata[3:0]};
            mem_write     <= 1'b1;
            state         <= S_MWR;
          end else begin
            // Plain data write keeps the mark bit already on tape.
            data_keep <= fe_readdata[2:0];
            mem_read  <= 1'b1;
            state     <= S_RMW_RD;
          end
        end
        S_RMW_RD: begin
          if (!mem_waitrequest) begin
            mem_read <= 1'b0;
            state    <= S_RMW_WAIT;
          end
        end
        S_RMW_WAIT: begin
          if (mem_readdatavalid) begin
            mem_writedata <= {4'b0, mem_readdata[3], data_keep};
            mem_write     <= 1'b1;
            state         <= S_MWR;
          end
        end
        S_MWR: begin
          if (!mem_waitrequest) begin
            mem_write <= 1'b0;
            state     <= S_STEP;
          end
        end
        S_FETCH: begin
          if (!mem_waitrequest) begin
            mem_read <= 1'b0;
            state    <= S_FWAIT;
          end
        end
        S_FWAIT: begin
          if (mem_readdatavalid) begin
            fe_writedata <= {4'b0, mem_readdata[3:0]};
            fe_write     <= 1'b1;
            state        <= S_GIVE;
          end
        end
        S_GIVE: begin
          fe_write <= 1'b0;
          state    <= S_STEP;
        end
        S_STEP: begin
          case (mot)
            2'd2: if (pos == LAST) eot <= 1'b1; else pos <= pos + AW'(1);
            2'd3: if (pos == '0)   eot <= 1'b1; else pos <= pos - AW'(1);
            default: ;
          endcase
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Capture comes last so a new edge wins over a same-cycle clear.
      if (wr_rise) begin
        pend_wr <= 1'b1;
        mot_wr  <= motion_now;
      end
      if (rd_rise) begin
        pend_rd <= 1'b1;
        mot_rd  <= motion_now;
      end
    end
  end

endmodule
